// File: rtl/timer_irq_ctrl_pkg.sv
// rtl/timer_irq_ctrl_pkg.sv - shared constants and types for the timer/interrupt block
package timer_irq_ctrl_pkg;

  localparam logic [7:0] ADDR_TH_DEFAULT      = 8'h00;
  localparam logic [7:0] ADDR_TL_DEFAULT      = 8'h04;
  localparam logic [7:0] ADDR_TCON_DEFAULT    = 8'h08;
  localparam logic [7:0] ADDR_SYSTICK_DEFAULT = 8'h14;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  localparam logic [31:0] RESET_VAL = 32'h0;
  localparam logic [31:0] TL_MAX    = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } timer_state_e;

endpackage

// File: rtl/timer_core.sv
// rtl/timer_core.sv - TH/TL reload counter with EN/IE/IS control bits
module timer_core
  import timer_irq_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        th_we_i,
  input  logic        tl_we_i,
  input  logic        tcon_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] th_o,
  output logic [31:0] tl_o,
  output logic [2:0]  tcon_o
);

  logic [31:0]  th_q, th_d;
  logic [31:0]  tl_q, tl_d;
  logic [2:0]   tcon_q, tcon_d;
  logic         overflow;
  timer_state_e state;

  // Mode follows the pre-edge EN bit, so a write clearing EN still lets this edge count/reload.
  assign state = tcon_q[TCON_EN] ? ST_COUNT : ST_IDLE;

  always_comb begin
    th_d     = th_q;
    tl_d     = tl_q;
    tcon_d   = tcon_q;
    overflow = 1'b0;

    if (th_we_i) begin
      th_d = wdata_i;
    end

    if (tl_we_i) begin
      tl_d = wdata_i;
    end else if (state == ST_COUNT) begin
      if (tl_q == TL_MAX) begin
        overflow = 1'b1;
        tl_d     = th_q;
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end

    if (tcon_we_i) begin
      tcon_d = wdata_i[2:0];
    end

    // Overflow set beats a software clear of IS in the same cycle.
    if (overflow && tcon_q[TCON_IE]) begin
      tcon_d[TCON_IS] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th_q   <= RESET_VAL;
      tl_q   <= RESET_VAL;
      tcon_q <= RESET_VAL[2:0];
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th_o   = th_q;
  assign tl_o   = tl_q;
  assign tcon_o = tcon_q;

endmodule

// File: rtl/timer_irq_ctrl.sv
// rtl/timer_irq_ctrl.sv - memory-mapped timer, SYSTICK and IRQ source for the MIPS core
module timer_irq_ctrl
  import timer_irq_ctrl_pkg::*;
#(
  parameter logic [7:0] ADDR_TH      = ADDR_TH_DEFAULT,
  parameter logic [7:0] ADDR_TL      = ADDR_TL_DEFAULT,
  parameter logic [7:0] ADDR_TCON    = ADDR_TCON_DEFAULT,
  parameter logic [7:0] ADDR_SYSTICK = ADDR_SYSTICK_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irqout
);

  logic [7:0]  addr_lo;
  logic        unused_addr_hi;
  logic        th_we, tl_we, tcon_we;
  logic [31:0] th, tl;
  logic [2:0]  tcon;
  logic [31:0] systick_q, systick_d;

  assign addr_lo        = addr[7:0];
  assign unused_addr_hi = ^addr[31:8];

  assign th_we   = wr && (addr_lo == ADDR_TH);
  assign tl_we   = wr && (addr_lo == ADDR_TL);
  assign tcon_we = wr && (addr_lo == ADDR_TCON);

  timer_core u_core (
    .clk       (clk),
    .reset     (reset),
    .th_we_i   (th_we),
    .tl_we_i   (tl_we),
    .tcon_we_i (tcon_we),
    .wdata_i   (wdata),
    .th_o      (th),
    .tl_o      (tl),
    .tcon_o    (tcon)
  );

  // SYSTICK is read-only; writes to its address fall through the decode.
  assign systick_d = systick_q + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      systick_q <= RESET_VAL;
    end else begin
      systick_q <= systick_d;
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (rd) begin
      if (addr_lo == ADDR_TH) begin
        rdata = th;
      end else if (addr_lo == ADDR_TL) begin
        rdata = tl;
      end else if (addr_lo == ADDR_TCON) begin
        rdata = {29'b0, tcon};
      end else if (addr_lo == ADDR_SYSTICK) begin
        rdata = systick_q;
      end
    end
  end

  assign irqout = tcon[TCON_IE] & tcon[TCON_IS];

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// tb/tb_timer_irq_ctrl.sv - directed self-checking bench for timer_irq_ctrl
module tb_timer_irq_ctrl;

  logic        clk;
  logic        reset;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irqout;

  int          checks;
  int          errors;
  logic [31:0] tick_model;
  logic [31:0] val;
  logic [31:0] st0;

  localparam logic [7:0] A_TH   = 8'h00;
  localparam logic [7:0] A_TL   = 8'h04;
  localparam logic [7:0] A_TCON = 8'h08;
  localparam logic [7:0] A_ST   = 8'h14;

  timer_irq_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .irqout (irqout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) tick_model <= 32'h0;
    else       tick_model <= tick_model + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
    wr    = 1'b1;
    addr  = 32'h4000_0000 | {24'h0, a};
    wdata = d;
    @(negedge clk);
    wr    = 1'b0;
  endtask

  task automatic rd_reg(input logic [7:0] a, output logic [31:0] d);
    rd   = 1'b1;
    addr = 32'h4000_0000 | {24'h0, a};
    #1;
    d    = rdata;
    rd   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    rd     = 1'b0;
    wr     = 1'b0;
    addr   = 32'h0;
    wdata  = 32'h0;
    idle(2);
    reset = 1'b0;

    rd_reg(A_TH, val);   check("reset_th", val, 32'h0);
    rd_reg(A_TCON, val); check("reset_tcon", val, 32'h0);
    check("reset_irq", {31'b0, irqout}, 32'h0);

    // Reset in the middle of counting
    wr_reg(A_TCON, 32'h1);
    wr_reg(A_TL, 32'h10);
    rd_reg(A_TL, val);   check("midcount_tl", val, 32'h10);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    rd_reg(A_TH, val);   check("rst2_th", val, 32'h0);
    rd_reg(A_TL, val);   check("rst2_tl", val, 32'h0);
    rd_reg(A_TCON, val); check("rst2_tcon", val, 32'h0);
    rd_reg(A_ST, val);   check("rst2_systick", val, 32'h0);
    check("rst2_irq", {31'b0, irqout}, 32'h0);

    // Reload and interrupt
    wr_reg(A_TH, 32'hFFFF_FFFC);
    wr_reg(A_TL, 32'hFFFF_FFFC);
    wr_reg(A_TCON, 32'h3);
    rd_reg(A_TL, val);   check("reload_start", val, 32'hFFFF_FFFC);
    idle(3);
    rd_reg(A_TL, val);   check("reload_max", val, 32'hFFFF_FFFF);
    check("reload_irq_pre", {31'b0, irqout}, 32'h0);
    idle(1);
    rd_reg(A_TL, val);   check("reload_tl", val, 32'hFFFF_FFFC);
    check("reload_irq", {31'b0, irqout}, 32'h1);
    rd_reg(A_TCON, val); check("reload_tcon", val, 32'h7);
    wr_reg(A_TCON, 32'h3);
    check("clear_irq", {31'b0, irqout}, 32'h0);
    rd_reg(A_TCON, val); check("clear_tcon", val, 32'h3);
    rd_reg(A_TL, val);   check("clear_tl", val, 32'hFFFF_FFFD);

    // Clear of IS in the overflow cycle loses to the overflow set
    idle(2);
    rd_reg(A_TL, val);   check("coll_max", val, 32'hFFFF_FFFF);
    wr_reg(A_TCON, 32'h3);
    rd_reg(A_TCON, val); check("coll_tcon", val, 32'h7);
    check("coll_irq", {31'b0, irqout}, 32'h1);
    rd_reg(A_TL, val);   check("coll_tl", val, 32'hFFFF_FFFC);

    // TH write in overflow cycle: reload uses old TH
    idle(3);
    wr_reg(A_TH, 32'h1000);
    rd_reg(A_TL, val);   check("thovf_tl", val, 32'hFFFF_FFFC);
    rd_reg(A_TH, val);   check("thovf_th", val, 32'h1000);

    // EN cleared in overflow cycle: reload still happens, IS set
    idle(3);
    wr_reg(A_TCON, 32'h0);
    rd_reg(A_TL, val);   check("enovf_tl", val, 32'h1000);
    rd_reg(A_TCON, val); check("enovf_tcon", val, 32'h4);
    check("enovf_irq", {31'b0, irqout}, 32'h0);

    // TL write during count
    wr_reg(A_TL, 32'h100);
    wr_reg(A_TCON, 32'h1);
    rd_reg(A_TL, val);   check("tlw_base", val, 32'h100);
    wr_reg(A_TL, 32'h5);
    rd_reg(A_TL, val);   check("tlw_new", val, 32'h5);
    idle(1);
    rd_reg(A_TL, val);   check("tlw_inc", val, 32'h6);

    // EN=0 hold while SYSTICK runs
    wr_reg(A_TL, 32'h1F);
    wr_reg(A_TCON, 32'h0);
    rd_reg(A_TL, val);   check("hold_tl0", val, 32'h20);
    rd_reg(A_ST, st0);   check("hold_st0", st0, tick_model);
    idle(10);
    rd_reg(A_TL, val);   check("hold_tl10", val, 32'h20);
    rd_reg(A_ST, val);   check("hold_st_delta", val - st0, 32'd10);

    // SYSTICK ignores writes
    wr_reg(A_ST, 32'hDEAD_BEEF);
    rd_reg(A_ST, val);   check("systick_ro", val, tick_model);

    // Unmapped address and gated read
    rd_reg(8'h0C, val);  check("unmapped", val, 32'h0);
    addr = 32'h4000_0004;
    #1;
    check("rd_low", rdata, 32'h0);

    // Read during write returns the pre-write value
    wr_reg(A_TH, 32'h1);
    rd    = 1'b1;
    wr    = 1'b1;
    addr  = 32'h4000_0000;
    wdata = 32'h2;
    #1;
    check("rdw_old", rdata, 32'h1);
    @(negedge clk);
    wr = 1'b0;
    rd = 1'b0;
    rd_reg(A_TH, val);   check("rdw_new", val, 32'h2);

    // Software interrupt
    wr_reg(A_TCON, 32'h6);
    check("sw_irq", {31'b0, irqout}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
